// File: rtl/psum_error_drain.sv
// Column-result drain: error compensation, saturation and an output FIFO.
// Three-state tile sequencer (IDLE/RUN/DRAIN) with overflow and error tally.
module psum_error_drain #(
  parameter int TILE_LEN = 8,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [23:0] partial_sum_in,
  input  logic [15:0] error_product_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data,
  output logic        out_sat,
  output logic        busy,
  output logic        tile_done,
  output logic        overflow,
  output logic [7:0]  err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] LAST = 8'(TILE_LEN - 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [7:0]    acc_cnt_q, acc_cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [24:0]   mem_q [DEPTH];
  logic [24:0]   mem_d [DEPTH];

  logic        rd;
  logic        wr;
  logic        acc;
  logic        full;
  logic [24:0] sum;
  logic [24:0] res;

  always_comb begin
    sum  = {1'b0, partial_sum_in} + {9'h0, error_product_in};
    // entry layout: {sat, data}
    res  = sum[24] ? {1'b1, 24'hFFFFFF} : {1'b0, sum[23:0]};
    full = (occ_q == FULL);
    rd   = (occ_q != '0) && out_ready;
    acc  = (state_q == RUN) && in_valid;
    wr   = acc && (!full || rd);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr) begin
      mem_d[wr_ptr_q] = res;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr && !rd) begin
      occ_d = occ_q + 1'b1;
    end else if (rd && !wr) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    err_cnt_d = err_cnt_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          acc_cnt_d = '0;
          err_cnt_d = '0;
          ovf_d     = 1'b0;
        end
      end
      RUN: begin
        if (acc) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (error_product_in != '0 && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          // a dropped result still counts toward the tile
          if (!wr) begin
            ovf_d = 1'b1;
          end
          if (acc_cnt_q == LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (occ_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      mem_q     <= mem_d;
    end
  end

  always_comb begin
    out_valid = (occ_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q][23:0] : '0;
    out_sat   = out_valid ? mem_q[rd_ptr_q][24] : 1'b0;
    busy      = (state_q == RUN) || (state_q == DRAIN);
    tile_done = (state_q == DRAIN) && (occ_q == '0);
    overflow  = ovf_q;
    err_count = err_cnt_q;
  end

endmodule

// File: tb/tb_psum_error_drain.sv
// Random and directed stimulus against a queue-based tile model.
// Directed tiles also pin the model with literal expectations.
module tb_psum_error_drain;

  localparam int TILE_LEN = 8;
  localparam int DEPTH    = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [23:0] partial_sum_in;
  logic [15:0] error_product_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_sat;
  logic        busy;
  logic        tile_done;
  logic        overflow;
  logic [7:0]  err_count;

  psum_error_drain #(
    .TILE_LEN(TILE_LEN),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_valid(in_valid),
    .partial_sum_in(partial_sum_in),
    .error_product_in(error_product_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sat(out_sat),
    .busy(busy),
    .tile_done(tile_done),
    .overflow(overflow),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: 0 idle, 1 collecting, 2 draining
  int          m_mode;
  int          m_acc;
  int          m_err;
  bit          m_ovf;
  logic [24:0] m_q[$];

  logic [23:0] seen[$];
  logic        seen_sat[$];
  int          td_cnt;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_acc  = 0;
    m_err  = 0;
    m_ovf  = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input bit st, input bit iv,
                            input logic [23:0] ps, input logic [15:0] ep,
                            input bit rdy);
    int n;
    bit rd, acc, wr;
    longint s;
    logic [24:0] r;
    n = m_q.size();
    s = longint'(ps) + longint'(ep);
    r = (s > 64'hFFFFFF) ? {1'b1, 24'hFFFFFF} : {1'b0, s[23:0]};
    rd  = (n > 0) && rdy;
    acc = (m_mode == 1) && iv;
    wr  = acc && ((n < DEPTH) || rd);
    if (rd) void'(m_q.pop_front());
    if (wr) m_q.push_back(r);
    if (acc) begin
      if (!wr) m_ovf = 1'b1;
      if (ep != 0 && m_err < 255) m_err++;
      m_acc++;
    end
    case (m_mode)
      0: if (st) begin
        m_mode = 1;
        m_acc  = 0;
        m_err  = 0;
        m_ovf  = 1'b0;
      end
      1: if (acc && m_acc == TILE_LEN) m_mode = 2;
      default: if (n == 0) m_mode = 0;
    endcase
  endtask

  task automatic cmp_all();
    bit has;
    has = m_q.size() > 0;
    chk("out_valid", out_valid, has);
    chk("out_data", out_data, has ? m_q[0][23:0] : 0);
    chk("out_sat", out_sat, has ? m_q[0][24] : 0);
    chk("busy", busy, m_mode != 0);
    chk("tile_done", tile_done, (m_mode == 2) && !has);
    chk("overflow", overflow, m_ovf);
    chk("err_count", err_count, m_err);
  endtask

  task automatic step(input bit st, input bit iv,
                      input logic [23:0] ps, input logic [15:0] ep,
                      input bit rdy);
    cmp_all();
    if (out_valid && rdy) begin
      seen.push_back(out_data);
      seen_sat.push_back(out_sat);
    end
    if (tile_done) td_cnt++;
    start            = st;
    in_valid         = iv;
    partial_sum_in   = ps;
    error_product_in = ep;
    out_ready        = rdy;
    model_step(st, iv, ps, ep, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    start    = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_sat", out_sat, 0);
    chk("rst busy", busy, 0);
    chk("rst tile_done", tile_done, 0);
    chk("rst overflow", overflow, 0);
    chk("rst err_count", err_count, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clr();
    seen.delete();
    seen_sat.delete();
    td_cnt = 0;
  endtask

  initial begin
    start            = 1'b0;
    in_valid         = 1'b0;
    partial_sum_in   = '0;
    error_product_in = '0;
    out_ready        = 1'b0;
    rst_n            = 1'b1;
    model_reset();
    clr();
    #2;
    do_reset();

    // in_valid before any start
    repeat (3) step(0, 1, 24'd5, 16'd5, 1);
    chk("idle no output", seen.size(), 0);

    // 8 back-to-back results, full throughput
    clr();
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 24'(100 * i), 16'(i), 1);
    repeat (4) step(0, 0, 0, 0, 1);
    chk("t1 count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      chk("t1 data", seen[i], 101 * i);
      chk("t1 sat", seen_sat[i], 0);
    end
    chk("t1 err_count", err_count, 7);
    chk("t1 tile_done pulses", td_cnt, 1);

    // saturation boundary
    clr();
    step(1, 0, 0, 0, 1);
    step(0, 1, 24'hFFFFF0, 16'h0020, 1);
    step(0, 1, 24'hFFFFF0, 16'h000F, 1);
    repeat (6) step(0, 1, 24'd1, 16'd0, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    chk("t2 count", seen.size(), 8);
    if (seen.size() >= 2) begin
      chk("t2 sat data", seen[0], 24'hFFFFFF);
      chk("t2 sat flag", seen_sat[0], 1);
      chk("t2 edge data", seen[1], 24'hFFFFFF);
      chk("t2 edge flag", seen_sat[1], 0);
    end

    // overflow with a stalled consumer; in_valid during drain
    clr();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 24'(1000 + i), 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("t3 overflow", overflow, 1);
    chk("t3 held data", out_data, 1000);
    chk("t3 busy", busy, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    chk("t3 first drain", seen.size(), 4);
    chk("t3 no early done", td_cnt, 0);
    for (int i = 5; i < 8; i++) step(0, 1, 24'(1000 + i), 0, 1);
    step(0, 1, 24'd9, 16'd9, 0);
    step(0, 1, 24'd9, 16'd9, 0);
    repeat (4) step(0, 0, 0, 0, 1);
    chk("t3 total", seen.size(), 7);
    if (seen.size() == 7) begin
      chk("t3 before gap", seen[3], 1003);
      chk("t3 after gap", seen[4], 1005);
      chk("t3 last", seen[6], 1007);
    end
    chk("t3 err_count", err_count, 0);
    chk("t3 tile_done pulses", td_cnt, 1);

    // full FIFO with simultaneous read and write
    clr();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 24'(i + 1), 0, 0);
    step(0, 1, 24'd5, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0);
    chk("t4 overflow", overflow, 0);
    chk("t4 head", out_data, 2);
    for (int i = 5; i < 8; i++) step(0, 1, 24'(i + 1), 0, 1);
    repeat (8) step(0, 0, 0, 0, 1);
    chk("t4 total", seen.size(), 8);
    chk("t4 tile_done pulses", td_cnt, 1);

    // reset mid-tile with two entries buffered
    clr();
    step(1, 0, 0, 0, 0);
    step(0, 1, 24'd11, 0, 0);
    step(0, 1, 24'd12, 0, 0);
    step(0, 1, 24'd13, 0, 1);
    chk("t5 buffered", out_valid, 1);
    do_reset();
    clr();
    step(0, 1, 24'd7, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 24'(20 + i), 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    chk("t5 count", seen.size(), 8);
    if (seen.size() > 0) chk("t5 first", seen[0], 20);
    chk("t5 overflow", overflow, 0);
    chk("t5 tile_done pulses", td_cnt, 1);

    // randomized traffic
    for (int c = 0; c < 5000; c++) begin
      bit st, iv, rdy;
      logic [23:0] ps;
      logic [15:0] ep;
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        st  = ($urandom_range(0, 7) == 0);
        iv  = ($urandom_range(0, 1) == 1);
        rdy = ((c / 64) % 3 == 0) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
        ps  = ($urandom_range(0, 3) == 0) ? 24'(24'hFFF000 | $urandom_range(0, 4095))
                                          : 24'($urandom);
        ep  = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
        step(st, iv, ps, ep, rdy);
      end
    end
    step(0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
